// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Per-register scoreboard beside the ID stage. It tracks in-flight register
// writes whose results arrive after a variable latency (ALU, load, mul/div).
// From that it decides stall, operand bypass select and WAW ordering, and it
// keeps a saturating count of stalled cycles.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           synchronous active-high reset
//   i_issue_valid   ID holds a valid instruction
//   i_issue_rs      source A index
//   i_issue_rt      source B index
//   i_issue_use_rt  instruction reads rt
//   i_issue_wr      instruction writes a register
//   i_issue_rd      destination index
//   i_issue_lat     cycles from issue until result is on bypass (0 treated as 1)
//   i_flush         squash instruction in ID
//   i_wb_valid      register-file write this cycle
//   i_wb_rd         destination of that write
//   o_stall         hold PC and IF/ID, bubble into ID/EX (combinational)
//   o_fwd_a         source A from bypass network (combinational)
//   o_fwd_b         source B from bypass network (combinational)
//   o_busy_mask     registered pending-write flag per register
//   o_stall_count   saturating count of stalled cycles (registered)
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
   parameter int REG_ADDR_W  = 5,
   parameter int LAT_W       = 3,
   parameter int STALL_CNT_W = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_issue_valid,
   input  logic [REG_ADDR_W-1:0]      i_issue_rs,
   input  logic [REG_ADDR_W-1:0]      i_issue_rt,
   input  logic                       i_issue_use_rt,
   input  logic                       i_issue_wr,
   input  logic [REG_ADDR_W-1:0]      i_issue_rd,
   input  logic [LAT_W-1:0]           i_issue_lat,
   input  logic                       i_flush,
   input  logic                       i_wb_valid,
   input  logic [REG_ADDR_W-1:0]      i_wb_rd,
   output logic                       o_stall,
   output logic                       o_fwd_a,
   output logic                       o_fwd_b,
   output logic [(2**REG_ADDR_W)-1:0] o_busy_mask,
   output logic [STALL_CNT_W-1:0]     o_stall_count
);

   localparam int NUM_REGS = 2**REG_ADDR_W;

   logic [NUM_REGS-1:0]    r_busy;
   logic [LAT_W-1:0]       r_cnt [NUM_REGS];
   logic [STALL_CNT_W-1:0] r_stall_count;

   logic [LAT_W-1:0] w_lat;
   logic             w_haz_a;
   logic             w_haz_b;
   logic             w_waw;
   logic             w_live;
   logic             w_stall;
   logic             w_accept;

   // Hazard detection and bypass select for the instruction currently in ID
   always_comb begin
      w_lat    = {LAT_W{1'b0}};
      w_haz_a  = 1'b0;
      w_haz_b  = 1'b0;
      w_waw    = 1'b0;
      w_live   = 1'b0;
      w_stall  = 1'b0;
      w_accept = 1'b0;
      o_fwd_a  = 1'b0;
      o_fwd_b  = 1'b0;

      // Latency 0 is illegal and is handled exactly like latency 1
      if (i_issue_lat == {LAT_W{1'b0}}) begin
         w_lat = {{(LAT_W-1){1'b0}}, 1'b1};
      end else begin
         w_lat = i_issue_lat;
      end

      // r0 is never busy, so no explicit r0 term is needed for source hazards
      w_haz_a = r_busy[i_issue_rs] && (r_cnt[i_issue_rs] != {LAT_W{1'b0}});
      w_haz_b = i_issue_use_rt && r_busy[i_issue_rt] &&
                (r_cnt[i_issue_rt] != {LAT_W{1'b0}});
      // A newer write must not land before (or together with) an older one
      w_waw   = i_issue_wr && (i_issue_rd != {REG_ADDR_W{1'b0}}) &&
                r_busy[i_issue_rd] && (r_cnt[i_issue_rd] >= w_lat);

      w_live   = i_issue_valid && !i_flush;
      w_stall  = w_live && (w_haz_a || w_haz_b || w_waw);
      w_accept = w_live && !w_stall;

      o_fwd_a = w_live && r_busy[i_issue_rs] &&
                (r_cnt[i_issue_rs] == {LAT_W{1'b0}}) &&
                (i_issue_rs != {REG_ADDR_W{1'b0}});
      o_fwd_b = w_live && i_issue_use_rt && r_busy[i_issue_rt] &&
                (r_cnt[i_issue_rt] == {LAT_W{1'b0}}) &&
                (i_issue_rt != {REG_ADDR_W{1'b0}});
   end

   assign o_stall       = w_stall;
   assign o_busy_mask   = r_busy;
   assign o_stall_count = r_stall_count;

   // Scoreboard update: issue beats writeback, writeback beats countdown
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= {NUM_REGS{1'b0}};
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= {LAT_W{1'b0}};
         end
      end else begin
         r_busy[0] <= 1'b0;
         r_cnt[0]  <= {LAT_W{1'b0}};
         for (int r = 1; r < NUM_REGS; r++) begin
            if (w_accept && i_issue_wr && (i_issue_rd == REG_ADDR_W'(r))) begin
               r_busy[r] <= 1'b1;
               r_cnt[r]  <= w_lat - {{(LAT_W-1){1'b0}}, 1'b1};
            end else if (i_wb_valid && (i_wb_rd == REG_ADDR_W'(r))) begin
               r_busy[r] <= 1'b0;
               r_cnt[r]  <= {LAT_W{1'b0}};
            end else if (r_busy[r] && (r_cnt[r] != {LAT_W{1'b0}})) begin
               r_cnt[r]  <= r_cnt[r] - {{(LAT_W-1){1'b0}}, 1'b1};
            end else begin
               r_cnt[r]  <= r_cnt[r];
            end
         end
      end
   end

   // Saturating stall-cycle counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_count <= {STALL_CNT_W{1'b0}};
      end else if (w_stall && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
         r_stall_count <= r_stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_stall_count <= r_stall_count;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
// Directed stimulus with hand-computed expectations pushed into a queue; a
// monitor on the falling edge pops and compares whenever a cycle is marked
// for checking. A second instance with a 2-bit stall counter shares the same
// stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rs;
   logic [4:0]  issue_rt;
   logic        issue_use_rt;
   logic        issue_wr;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_lat;
   logic        flush;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        stall, fwd_a, fwd_b;
   logic [31:0] busy_mask;
   logic [15:0] stall_count;
   logic        stall2, fwd_a2, fwd_b2;
   logic [31:0] busy_mask2;
   logic [1:0]  stall_count2;

   typedef struct {
      string       name;
      logic        stall;
      logic        fa;
      logic        fb;
      logic [31:0] mask;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t q[$];
   logic chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_unit u_dut (
      .i_clk(clk), .i_rst(rst), .i_issue_valid(issue_valid),
      .i_issue_rs(issue_rs), .i_issue_rt(issue_rt), .i_issue_use_rt(issue_use_rt),
      .i_issue_wr(issue_wr), .i_issue_rd(issue_rd), .i_issue_lat(issue_lat),
      .i_flush(flush), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
      .o_stall(stall), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
      .o_busy_mask(busy_mask), .o_stall_count(stall_count)
   );

   hazard_scoreboard_unit #(.STALL_CNT_W(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_issue_valid(issue_valid),
      .i_issue_rs(issue_rs), .i_issue_rt(issue_rt), .i_issue_use_rt(issue_use_rt),
      .i_issue_wr(issue_wr), .i_issue_rd(issue_rd), .i_issue_lat(issue_lat),
      .i_flush(flush), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
      .o_stall(stall2), .o_fwd_a(fwd_a2), .o_fwd_b(fwd_b2),
      .o_busy_mask(busy_mask2), .o_stall_count(stall_count2)
   );

   // Monitor: compare the DUT against the oldest pending expectation
   always @(negedge clk) begin
      if (chk_en) begin
         checks = checks + 1;
         if (q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL queue_underflow: no expectation for checked cycle");
         end else begin
            exp_t e;
            e = q.pop_front();
            if (stall !== e.stall) begin
               errors = errors + 1;
               $display("FAIL %s.stall: got %b expected %b", e.name, stall, e.stall);
            end
            checks = checks + 1;
            if (fwd_a !== e.fa) begin
               errors = errors + 1;
               $display("FAIL %s.fwd_a: got %b expected %b", e.name, fwd_a, e.fa);
            end
            checks = checks + 1;
            if (fwd_b !== e.fb) begin
               errors = errors + 1;
               $display("FAIL %s.fwd_b: got %b expected %b", e.name, fwd_b, e.fb);
            end
            checks = checks + 1;
            if (busy_mask !== e.mask) begin
               errors = errors + 1;
               $display("FAIL %s.busy_mask: got %h expected %h", e.name, busy_mask, e.mask);
            end
            checks = checks + 1;
            if (stall_count !== e.cnt) begin
               errors = errors + 1;
               $display("FAIL %s.stall_count: got %0d expected %0d", e.name, stall_count, e.cnt);
            end
            checks = checks + 1;
            if (stall_count2 !== e.cnt2) begin
               errors = errors + 1;
               $display("FAIL %s.stall_count_w2: got %0d expected %0d", e.name, stall_count2, e.cnt2);
            end
         end
      end
   end

   task automatic idle();
      issue_valid = 1'b0; issue_rs = 5'd0; issue_rt = 5'd0; issue_use_rt = 1'b0;
      issue_wr = 1'b0; issue_rd = 5'd0; issue_lat = 3'd1; flush = 1'b0;
      wb_valid = 1'b0; wb_rd = 5'd0; rst = 1'b0;
   endtask

   task automatic set_issue(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                            input logic wr, input logic [4:0] rd, input logic [2:0] lat);
      issue_valid = 1'b1; issue_rs = rs; issue_rt = rt; issue_use_rt = use_rt;
      issue_wr = wr; issue_rd = rd; issue_lat = lat;
   endtask

   task automatic set_wb(input logic [4:0] rd);
      wb_valid = 1'b1; wb_rd = rd;
   endtask

   // Push expectation for the cycle whose inputs are now applied, then advance
   task automatic expect_step(input string name, input logic st, input logic fa, input logic fb,
                              input logic [31:0] mask, input logic [15:0] cnt);
      exp_t e;
      e.name = name; e.stall = st; e.fa = fa; e.fb = fb; e.mask = mask; e.cnt = cnt;
      e.cnt2 = (cnt > 16'd3) ? 2'd3 : cnt[1:0];
      q.push_back(e);
      chk_en = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b0;
      idle();
   endtask

   task automatic nocheck_step();
      @(posedge clk); #1;
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      idle();
      expect_step("reset", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);

      // 1: add r3 (lat1) then sub r4,r3 forwards without stall
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 3'd1);
      expect_step("t1_add", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);
      set_issue(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 3'd1);
      expect_step("t1_sub", 1'b0, 1'b1, 1'b0, 32'h0000_0008, 16'd0);
      set_wb(5'd3);
      expect_step("t1_wb3", 1'b0, 1'b0, 1'b0, 32'h0000_0018, 16'd0);
      set_wb(5'd4);
      expect_step("t1_wb4", 1'b0, 1'b0, 1'b0, 32'h0000_0010, 16'd0);

      // 2: lw r5 (lat2), dependent add stalls once then forwards
      set_issue(5'd1, 5'd0, 1'b0, 1'b1, 5'd5, 3'd2);
      expect_step("t2_lw", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);
      set_issue(5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 3'd1);
      expect_step("t2_use_stall", 1'b1, 1'b0, 1'b0, 32'h0000_0020, 16'd0);
      set_issue(5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 3'd1);
      expect_step("t2_use_fwd", 1'b0, 1'b1, 1'b0, 32'h0000_0020, 16'd1);
      set_wb(5'd5);
      expect_step("t2_wb5", 1'b0, 1'b0, 1'b0, 32'h0000_0060, 16'd1);
      set_wb(5'd6);
      expect_step("t2_wb6", 1'b0, 1'b0, 1'b0, 32'h0000_0040, 16'd1);

      // 3: mul r7 (lat4) then add r7 (lat1): WAW stall for three cycles
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 3'd4);
      expect_step("t3_mul", 1'b0, 1'b0, 1'b0, 32'h0, 16'd1);
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 3'd1);
      expect_step("t3_waw1", 1'b1, 1'b0, 1'b0, 32'h0000_0080, 16'd1);
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 3'd1);
      expect_step("t3_waw2", 1'b1, 1'b0, 1'b0, 32'h0000_0080, 16'd2);
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 3'd1);
      expect_step("t3_waw3", 1'b1, 1'b0, 1'b0, 32'h0000_0080, 16'd3);
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 3'd1);
      expect_step("t3_accept", 1'b0, 1'b0, 1'b0, 32'h0000_0080, 16'd4);
      set_wb(5'd7);
      expect_step("t3_wb7", 1'b0, 1'b0, 1'b0, 32'h0000_0080, 16'd4);

      // 4: issue r8 (lat3) together with writeback of r8: issue wins, cnt=2
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 3'd1);
      expect_step("t4_first", 1'b0, 1'b0, 1'b0, 32'h0, 16'd4);
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 3'd3);
      set_wb(5'd8);
      expect_step("t4_issue_wb", 1'b0, 1'b0, 1'b0, 32'h0000_0100, 16'd4);
      set_issue(5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 3'd1);
      expect_step("t4_rd_cnt2", 1'b1, 1'b0, 1'b0, 32'h0000_0100, 16'd4);
      set_issue(5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 3'd1);
      expect_step("t4_rd_cnt1", 1'b1, 1'b0, 1'b0, 32'h0000_0100, 16'd5);
      set_issue(5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 3'd1);
      expect_step("t4_rd_fwd", 1'b0, 1'b1, 1'b0, 32'h0000_0100, 16'd6);
      set_wb(5'd8);
      expect_step("t4_wb8", 1'b0, 1'b0, 1'b0, 32'h0000_0100, 16'd6);

      // 5: writes to r0 never mark busy; stray writeback has no effect
      set_issue(5'd1, 5'd0, 1'b0, 1'b1, 5'd0, 3'd3);
      expect_step("t5_wr_r0", 1'b0, 1'b0, 1'b0, 32'h0, 16'd6);
      set_issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 3'd1);
      set_wb(5'd9);
      expect_step("t5_rd_r0", 1'b0, 1'b0, 1'b0, 32'h0, 16'd6);
      set_wb(5'd9);
      expect_step("t5_wb9", 1'b0, 1'b0, 1'b0, 32'h0000_0200, 16'd6);

      // 6: flush suppresses stall and issue; rt hazard and use_rt gating
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 3'd4);
      expect_step("t6_mul", 1'b0, 1'b0, 1'b0, 32'h0, 16'd6);
      set_issue(5'd10, 5'd2, 1'b1, 1'b1, 5'd11, 3'd1);
      flush = 1'b1;
      expect_step("t6_flush", 1'b0, 1'b0, 1'b0, 32'h0000_0400, 16'd6);
      expect_step("t6_after_flush", 1'b0, 1'b0, 1'b0, 32'h0000_0400, 16'd6);
      set_issue(5'd1, 5'd10, 1'b1, 1'b0, 5'd0, 3'd1);
      expect_step("t6_rt_stall", 1'b1, 1'b0, 1'b0, 32'h0000_0400, 16'd6);
      set_issue(5'd1, 5'd10, 1'b1, 1'b0, 5'd0, 3'd1);
      expect_step("t6_rt_fwd", 1'b0, 1'b0, 1'b1, 32'h0000_0400, 16'd7);
      set_issue(5'd1, 5'd10, 1'b0, 1'b0, 5'd0, 3'd1);
      expect_step("t6_rt_unused", 1'b0, 1'b0, 1'b0, 32'h0000_0400, 16'd7);
      set_wb(5'd10);
      expect_step("t6_wb10", 1'b0, 1'b0, 1'b0, 32'h0000_0400, 16'd7);

      // Latency 0 behaves as latency 1
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 3'd0);
      expect_step("lat0_issue", 1'b0, 1'b0, 1'b0, 32'h0, 16'd7);
      set_issue(5'd12, 5'd0, 1'b0, 1'b0, 5'd0, 3'd1);
      expect_step("lat0_fwd", 1'b0, 1'b1, 1'b0, 32'h0000_1000, 16'd7);

      // Reset mid-operation discards pending entries; stray wb ignored afterwards
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 3'd4);
      expect_step("rst_pre", 1'b0, 1'b0, 1'b0, 32'h0000_1000, 16'd7);
      set_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd14, 3'd1);
      rst = 1'b1;
      nocheck_step();
      set_wb(5'd13);
      expect_step("rst_stray_wb", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);
      set_issue(5'd13, 5'd14, 1'b1, 1'b0, 5'd0, 3'd1);
      expect_step("rst_after", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);

      @(negedge clk);
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
